// File: rtl/bit_serializer.sv
// bit_serializer: feeds the sequence recognizer one bit per clock.
// Parallel words arrive over a valid/ready handshake and are shifted out on x.
// A one-word pending buffer lets consecutive words stream with no idle cycles.
// Between words x is held low and x_valid is low.
// Optional feature: define SERIAL_PARITY_EN to append a parity bit to every
// frame (even parity, or odd parity when PARITY_ODD=1).

module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             word_done
);

`ifdef SERIAL_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
  // PARITY_ODD has no effect without the parity bit; it is kept for a uniform
  // parameter list across both builds.
  localparam bit unused_parity_odd = PARITY_ODD;
`endif
  localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt, shift_adv;
  logic [WIDTH-1:0] pend_reg, pend_nxt;
  logic             pend_full, pend_full_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic             x_nxt, x_valid_nxt, word_done_nxt, busy_nxt;
  logic             transfer, last_bit, do_load;
  logic [WIDTH-1:0] load_word;
`ifdef SERIAL_PARITY_EN
  logic             par_reg, par_nxt;
`endif

  // Ready only reflects the pending buffer, so it never depends on load_valid.
  assign load_ready = !pend_full;

  // Next-state logic: the current bit is already on x; this picks what x,
  // the counter and the buffers hold after the coming edge.
  always_comb begin
    transfer      = load_valid && load_ready;
    last_bit      = (count == CW'(FRAME - 1));
    shift_adv     = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
    state_nxt     = state;
    shift_nxt     = shift_reg;
    pend_nxt      = pend_reg;
    pend_full_nxt = pend_full;
    count_nxt     = count;
    x_nxt         = x;
    word_done_nxt = word_done;
    do_load       = 1'b0;
    load_word     = data_in;
`ifdef SERIAL_PARITY_EN
    par_nxt       = par_reg;
`endif
    case (state)
      IDLE: begin
        if (transfer) begin
          do_load   = 1'b1;
          load_word = data_in;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          count_nxt     = count + CW'(1);
          shift_nxt     = shift_adv;
          x_nxt         = MSB_FIRST ? shift_adv[WIDTH-1] : shift_adv[0];
`ifdef SERIAL_PARITY_EN
          if (count == CW'(WIDTH - 1)) begin
            x_nxt = par_reg;
          end
`endif
          word_done_nxt = (count == CW'(FRAME - 2));
          if (transfer) begin
            pend_nxt      = data_in;
            pend_full_nxt = 1'b1;
          end
        end else if (pend_full) begin
          do_load       = 1'b1;
          load_word     = pend_reg;
          pend_full_nxt = 1'b0;
        end else if (transfer) begin
          do_load   = 1'b1;
          load_word = data_in;
        end else begin
          state_nxt     = IDLE;
          shift_nxt     = '0;
          count_nxt     = '0;
          x_nxt         = 1'b0;
          word_done_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        x_nxt     = 1'b0;
      end
    endcase

    if (do_load) begin
      state_nxt     = SHIFT;
      shift_nxt     = load_word;
      count_nxt     = '0;
      x_nxt         = MSB_FIRST ? load_word[WIDTH-1] : load_word[0];
      word_done_nxt = 1'b0;
`ifdef SERIAL_PARITY_EN
      par_nxt       = (^load_word) ^ PARITY_ODD;
`endif
    end

    x_valid_nxt = (state_nxt == SHIFT);
    busy_nxt    = x_valid_nxt || pend_full_nxt;
  end

  // State and registered outputs; reset discards any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      pend_reg  <= '0;
      pend_full <= 1'b0;
      count     <= '0;
      x         <= 1'b0;
      x_valid   <= 1'b0;
      word_done <= 1'b0;
      busy      <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      pend_reg  <= pend_nxt;
      pend_full <= pend_full_nxt;
      count     <= count_nxt;
      x         <= x_nxt;
      x_valid   <= x_valid_nxt;
      word_done <= word_done_nxt;
      busy      <= busy_nxt;
`ifdef SERIAL_PARITY_EN
      par_reg   <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed bench for bit_serializer.
// Two instances: default MSB-first, and an LSB-first one.
// Expected bit streams are written out by hand as transmit-order constants.

module tb_bit_serializer;

  localparam int WIDTH = 8;
`ifdef SERIAL_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] m_data, l_data;
  logic       m_valid, l_valid;
  logic       m_ready, m_x, m_xv, m_busy, m_done;
  logic       l_ready, l_x, l_xv, l_busy, l_done;

  int compared   = 0;
  int mismatched = 0;

  logic       exp_x[$];
  logic       exp_done[$];
  logic [7:0] tx_words[$];
  logic       ready_log[64];

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_ODD(1'b0)) u_msb (
    .clk(clk), .reset(reset), .data_in(m_data), .load_valid(m_valid),
    .load_ready(m_ready), .x(m_x), .x_valid(m_xv), .busy(m_busy), .word_done(m_done)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_ODD(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .data_in(l_data), .load_valid(l_valid),
    .load_ready(l_ready), .x(l_x), .x_valid(l_xv), .busy(l_busy), .word_done(l_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic driveInput(input bit lsb, input logic [7:0] w, input logic v);
    if (lsb) begin
      l_data  = w;
      l_valid = v;
    end else begin
      m_data  = w;
      m_valid = v;
    end
  endtask

  task automatic clearStream();
    exp_x.delete();
    exp_done.delete();
    tx_words.delete();
  endtask

  // bits: data bits written left to right in transmit order; par: parity bit.
  task automatic pushFrame(input logic [7:0] bits, input logic par);
    for (int i = 7; i >= 0; i--) begin
      exp_x.push_back(bits[i]);
      exp_done.push_back((i == 0) && (FRAME == WIDTH));
    end
    if (FRAME > WIDTH) begin
      exp_x.push_back(par);
      exp_done.push_back(1'b1);
    end
  endtask

  // Source model: presents tx_words in order, holding each until accepted,
  // while checking every cycle of the expected gapless bit stream.
  task automatic applyStimulus(input string tag, input bit lsb);
    int   widx;
    logic xfer;
    logic rdy;
    widx = 0;
    @(negedge clk);
    driveInput(lsb, tx_words[0], 1'b1);
    xfer = lsb ? l_ready : m_ready;
    for (int i = 0; i < exp_x.size(); i++) begin
      @(negedge clk);
      if (xfer) widx++;
      rdy = lsb ? l_ready : m_ready;
      if (widx < tx_words.size()) driveInput(lsb, tx_words[widx], 1'b1);
      else driveInput(lsb, 8'h00, 1'b0);
      xfer = (widx < tx_words.size()) && rdy;
      if (i < 64) ready_log[i] = rdy;
      checkOutput($sformatf("%s x[%0d]", tag, i), lsb ? l_x : m_x, exp_x[i]);
      checkOutput($sformatf("%s x_valid[%0d]", tag, i), lsb ? l_xv : m_xv, 1);
      checkOutput($sformatf("%s word_done[%0d]", tag, i), lsb ? l_done : m_done, exp_done[i]);
      checkOutput($sformatf("%s busy[%0d]", tag, i), lsb ? l_busy : m_busy, 1);
    end
    @(negedge clk);
    if (xfer) widx++;
    driveInput(lsb, 8'h00, 1'b0);
    checkOutput({tag, " accepted"}, widx, tx_words.size());
    checkOutput({tag, " idle x"}, lsb ? l_x : m_x, 0);
    checkOutput({tag, " idle x_valid"}, lsb ? l_xv : m_xv, 0);
    checkOutput({tag, " idle busy"}, lsb ? l_busy : m_busy, 0);
    checkOutput({tag, " idle word_done"}, lsb ? l_done : m_done, 0);
    checkOutput({tag, " idle load_ready"}, lsb ? l_ready : m_ready, 1);
  endtask

  // Main sequence of directed tests.
  initial begin
    reset = 1'b0;
    driveInput(1'b0, 8'h00, 1'b0);
    driveInput(1'b1, 8'h00, 1'b0);
    $display("[TB] start, FRAME=%0d", FRAME);

    @(negedge clk);
    checkOutput("reset x", m_x, 0);
    checkOutput("reset x_valid", m_xv, 0);
    checkOutput("reset word_done", m_done, 0);
    checkOutput("reset busy", m_busy, 0);
    checkOutput("reset load_ready", m_ready, 1);
    @(negedge clk);
    reset = 1'b1;

    // Single word 0x2D, MSB first.
    clearStream();
    tx_words.push_back(8'h2D);
    pushFrame(8'b0010_1101, 1'b0);
    applyStimulus("single", 1'b0);

    // Back-to-back 0xA5 then 0x3C.
    clearStream();
    tx_words.push_back(8'hA5);
    tx_words.push_back(8'h3C);
    pushFrame(8'b1010_0101, 1'b0);
    pushFrame(8'b0011_1100, 1'b0);
    applyStimulus("b2b", 1'b0);
    checkOutput("b2b ready after pend", ready_log[1], 0);
    checkOutput("b2b ready after handoff", ready_log[FRAME], 1);

    // Backpressure: 0xFF is held off while 0x3C sits in pending.
    clearStream();
    tx_words.push_back(8'hA5);
    tx_words.push_back(8'h3C);
    tx_words.push_back(8'hFF);
    pushFrame(8'b1010_0101, 1'b0);
    pushFrame(8'b0011_1100, 1'b0);
    pushFrame(8'b1111_1111, 1'b0);
    applyStimulus("bp", 1'b0);
    checkOutput("bp ready bit1", ready_log[1], 0);
    checkOutput("bp ready last bit", ready_log[FRAME-1], 0);
    checkOutput("bp ready handoff", ready_log[FRAME], 1);
    checkOutput("bp ready refilled", ready_log[FRAME+1], 0);
    checkOutput("bp ready handoff2", ready_log[2*FRAME], 1);

    // Reset in the middle of 0xF0.
    @(negedge clk);
    driveInput(1'b0, 8'hF0, 1'b1);
    @(negedge clk);
    driveInput(1'b0, 8'h00, 1'b0);
    checkOutput("rst bit0", m_x, 1);
    @(negedge clk);
    checkOutput("rst bit1", m_x, 1);
    @(negedge clk);
    checkOutput("rst bit2", m_x, 1);
    reset = 1'b0;
    #1;
    checkOutput("rst async x", m_x, 0);
    checkOutput("rst async x_valid", m_xv, 0);
    checkOutput("rst async busy", m_busy, 0);
    checkOutput("rst async word_done", m_done, 0);
    checkOutput("rst async load_ready", m_ready, 1);
    @(negedge clk);
    checkOutput("rst held word_done", m_done, 0);
    checkOutput("rst held x_valid", m_xv, 0);
    reset = 1'b1;
    clearStream();
    tx_words.push_back(8'h5A);
    pushFrame(8'b0101_1010, 1'b0);
    applyStimulus("post_rst", 1'b0);

    // LSB-first instance: 0x03 goes out as 1,1,0,0,0,0,0,0.
    clearStream();
    tx_words.push_back(8'h03);
    pushFrame(8'b1100_0000, 1'b0);
    applyStimulus("lsb", 1'b1);

    // Parity words 0xB4 (even count -> 0) and 0x07 (odd count -> 1).
    clearStream();
    tx_words.push_back(8'hB4);
    tx_words.push_back(8'h07);
    pushFrame(8'b1011_0100, 1'b0);
    pushFrame(8'b0000_0111, 1'b1);
    applyStimulus("parity", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
